// File: rtl/sram_arbiter_ctrl_if.sv
// sram_arbiter_ctrl_if: groups the core-side request ports (IFU, MEM) and
// the board SRAM pins of sram_arbiter_ctrl.
//   slave  : the arbiter side (takes requests, drives SRAM pins)
//   master : the core/board side (drives requests, returns pad read data)
interface sram_arbiter_ctrl_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  ifu_req;
  logic [ADDR_WIDTH-1:0] ifu_addr;
  logic [DATA_WIDTH-1:0] ifu_rdata;
  logic                  ifu_ack;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_dq_o;
  logic [DATA_WIDTH-1:0] sram_dq_i;
  logic                  sram_dq_oe;
  logic                  sram_ce_n;
  logic                  sram_oe_n;
  logic                  sram_we_n;
  logic [BE_WIDTH-1:0]   sram_be_n;

  modport slave (
    input  ifu_req, ifu_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be, sram_dq_i,
    output ifu_rdata, ifu_ack, mem_rdata, mem_ack,
    output sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );

  modport master (
    output ifu_req, ifu_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be, sram_dq_i,
    input  ifu_rdata, ifu_ack, mem_rdata, mem_ack,
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
  );
endinterface

// File: rtl/sram_arbiter_ctrl.sv
// sram_arbiter_ctrl: shares one asynchronous SRAM between the IFU (read-only)
// and MEM (read/write) ports with round-robin arbitration. Each access runs
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES strobe cycles) -> DONE; all outputs
// are registered.
// Ports:
//   clk  RAM clock
//   rst  synchronous active-high reset
//   bus  sram_arbiter_ctrl_if.slave: IFU/MEM req/ack ports and SRAM pins
module sram_arbiter_ctrl #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_arbiter_ctrl_if.slave     bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  last_mem_q, last_mem_d;   // last grant went to MEM
  logic                  gnt_mem_q, gnt_mem_d;     // current access belongs to MEM
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dq_o_q, dq_o_d;
  logic                  dq_oe_q, dq_oe_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic [BE_WIDTH-1:0]   be_n_q, be_n_d;
  logic [DATA_WIDTH-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  ifu_ack_q, ifu_ack_d;
  logic                  mem_ack_q, mem_ack_d;
  logic                  pick_mem;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_mem_d  = last_mem_q;
    gnt_mem_d   = gnt_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    dq_o_d      = dq_o_q;
    dq_oe_d     = dq_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    be_n_d      = be_n_q;
    ifu_rdata_d = ifu_rdata_q;
    mem_rdata_d = mem_rdata_q;
    ifu_ack_d   = 1'b0;
    mem_ack_d   = 1'b0;
    pick_mem    = 1'b0;
    case (state_q)
      IDLE: if (bus.ifu_req || bus.mem_req) begin
        // MEM wins unless both request and MEM was served last.
        pick_mem   = bus.mem_req && !(bus.ifu_req && last_mem_q);
        gnt_mem_d  = pick_mem;
        last_mem_d = pick_mem;
        we_d       = pick_mem && bus.mem_we;
        addr_d     = pick_mem ? bus.mem_addr : bus.ifu_addr;
        be_n_d     = pick_mem ? ~bus.mem_be : '0;
        if (pick_mem && bus.mem_we) dq_o_d = bus.mem_wdata;
        dq_oe_d    = pick_mem && bus.mem_we;
        ce_n_d     = 1'b0;
        state_d    = SETUP;
      end
      SETUP: begin
        cnt_d   = CW'(WAIT_CYCLES - 1);
        oe_n_d  = we_q;
        we_n_d  = !we_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Final strobe edge: oe_n is still low here, so the pad data is valid.
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          state_d = DONE;
          if (gnt_mem_q) mem_ack_d = 1'b1;
          else           ifu_ack_d = 1'b1;
          if (!we_q) begin
            if (gnt_mem_q) mem_rdata_d = bus.sram_dq_i;
            else           ifu_rdata_d = bus.sram_dq_i;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        // ce_n/addr/be_n/dq_oe were held through DONE for write hold time.
        ce_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        be_n_d  = '1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_mem_q  <= 1'b0;
      gnt_mem_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dq_o_q      <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= '1;
      ifu_rdata_q <= '0;
      mem_rdata_q <= '0;
      ifu_ack_q   <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_mem_q  <= last_mem_d;
      gnt_mem_q   <= gnt_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
      ifu_rdata_q <= ifu_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      ifu_ack_q   <= ifu_ack_d;
      mem_ack_q   <= mem_ack_d;
    end
  end

  assign bus.ifu_rdata  = ifu_rdata_q;
  assign bus.ifu_ack    = ifu_ack_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.mem_ack    = mem_ack_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_dq_o  = dq_o_q;
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.sram_ce_n  = ce_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_be_n  = be_n_q;
endmodule
